// File: rtl/i2c_req_arbiter.sv
// Round-robin sequencer sharing one i2c_controller write engine among NUM_REQ clients.
// req_ack/i2c_start are registered one cycle after the IDLE decision; other requesters stall until the next IDLE.
module i2c_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_dev_addr,
  input  logic [8*NUM_REQ-1:0]       req_reg_addr,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       req_err,
  output logic                       i2c_start,
  output logic [7:0]                 i2c_dev_addr,
  output logic [7:0]                 i2c_reg_addr,
  output logic [7:0]                 i2c_data,
  input  logic                       i2c_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int GW = $clog2(NUM_REQ);
  localparam logic [23:0] CNT_LAST = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  typedef struct packed {
    logic [7:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } payload_t;

  state_t        state;
  logic          rdy_meta;
  logic          rdy_s;
  logic [GW-1:0] ptr;
  logic [GW-1:0] win;
  logic          win_vld;
  payload_t      win_pay;
  payload_t      pay;
  logic [23:0]   cnt;
  logic [23:0]   cnt_inc;
  logic          timeout;

  // Search starts just after the last owner so it gets lowest priority next time.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    win_pay = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && req_valid[idx[GW-1:0]]) begin
        win_vld          = 1'b1;
        win              = idx[GW-1:0];
        win_pay.dev_addr = req_dev_addr[{idx[GW-1:0], 3'b000} +: 8];
        win_pay.reg_addr = req_reg_addr[{idx[GW-1:0], 3'b000} +: 8];
        win_pay.data     = req_data[{idx[GW-1:0], 3'b000} +: 8];
      end
    end
  end

  assign cnt_inc = (cnt == 24'hFF_FFFF) ? cnt : cnt + 24'd1;
  assign timeout = (cnt == CNT_LAST);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rdy_meta  <= 1'b0;
      rdy_s     <= 1'b0;
      state     <= IDLE;
      ptr       <= GW'(NUM_REQ - 1);
      grant_id  <= '0;
      pay       <= '0;
      cnt       <= '0;
      req_ack   <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
      i2c_start <= 1'b0;
    end else begin
      rdy_meta <= i2c_ready;
      rdy_s    <= rdy_meta;
      req_ack  <= '0;
      req_done <= '0;
      req_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (rdy_s && win_vld) begin
            state        <= LAUNCH;
            pay          <= win_pay;
            grant_id     <= win;
            ptr          <= win;
            req_ack[win] <= 1'b1;
            i2c_start    <= 1'b1;
            cnt          <= '0;
          end
        end
        LAUNCH: begin
          // start stays up until the controller's slow clock has seen it and dropped ready
          if (timeout) begin
            i2c_start          <= 1'b0;
            req_done[grant_id] <= 1'b1;
            req_err            <= 1'b1;
            state              <= DONE;
          end else if (!rdy_s) begin
            i2c_start <= 1'b0;
            cnt       <= '0;
            state     <= WAIT;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT: begin
          if (rdy_s) begin
            req_done[grant_id] <= 1'b1;
            state              <= DONE;
          end else if (timeout) begin
            req_done[grant_id] <= 1'b1;
            req_err            <= 1'b1;
            state              <= DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign i2c_dev_addr = pay.dev_addr;
  assign i2c_reg_addr = pay.reg_addr;
  assign i2c_data     = pay.data;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: directed scenarios plus randomized traffic against a round-robin reference model.
module tb_i2c_req_arbiter;
  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int DELAY          = 2;
  localparam int GW             = $clog2(NUM_REQ);

  logic                 clk_in = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_dev_addr;
  logic [8*NUM_REQ-1:0] req_reg_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   req_done;
  logic                 req_err;
  logic                 i2c_start;
  logic [7:0]           i2c_dev_addr;
  logic [7:0]           i2c_reg_addr;
  logic [7:0]           i2c_data;
  logic                 i2c_ready;
  logic                 busy;
  logic [GW-1:0]        grant_id;

  int vectors     = 0;
  int miscompares = 0;

  i2c_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk_in(clk_in), .reset(reset), .req_valid(req_valid),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_data(req_data),
    .req_ack(req_ack), .req_done(req_done), .req_err(req_err), .i2c_start(i2c_start),
    .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr), .i2c_data(i2c_data),
    .i2c_ready(i2c_ready), .busy(busy), .grant_id(grant_id)
  );

  always #10 clk_in = ~clk_in;

  // Controller model: sees start, drops ready DELAY cycles later, stays busy a random while.
  logic model_en     = 1'b1;
  logic model_hang   = 1'b0;
  logic forced_ready = 1'b1;
  logic model_ready  = 1'b1;
  int   m_phase      = 0;
  int   m_cnt        = 0;

  assign i2c_ready = model_en ? model_ready : forced_ready;

  always @(negedge clk_in) begin
    if (!model_en) begin
      m_phase     = 0;
      model_ready = 1'b1;
    end else begin
      case (m_phase)
        0: begin
          model_ready = 1'b1;
          if (i2c_start === 1'b1) begin m_phase = 1; m_cnt = DELAY; end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin model_ready = 1'b0; m_phase = 2; m_cnt = $urandom_range(6, 12); end
        end
        2: begin
          if (!model_hang) begin
            m_cnt--;
            if (m_cnt == 0) begin model_ready = 1'b1; m_phase = 3; end
          end
        end
        default: if (i2c_start !== 1'b1) m_phase = 0;
      endcase
    end
  end

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin cyc(); n++; end while (req_ack == '0 && n < 100);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin cyc(); n++; end while (req_done == '0 && n < 300);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({req_ack, req_done, req_err, i2c_start} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ack=%b done=%b err=%b start=%b, want all 0", req_ack, req_done, req_err, i2c_start);
    end
    vectors++;
    if ({i2c_dev_addr, i2c_reg_addr, i2c_data, busy, grant_id} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: dev=%h reg=%h dat=%h busy=%b id=%0d, want 0", i2c_dev_addr, i2c_reg_addr, i2c_data, busy, grant_id);
    end
    repeat (4) cyc();
    vectors++;
    if (busy !== 1'b0 || req_ack !== '0) begin
      miscompares++;
      $display("FAIL idle_no_req: busy=%b ack=%b, want 0/0", busy, req_ack);
    end
  endtask

  task automatic test_single();
    int n;
    logic seen_low;
    req_dev_addr[15:8] = 8'h3C;
    req_reg_addr[15:8] = 8'h10;
    req_data[15:8]     = 8'hA5;
    req_valid          = 4'b0010;
    wait_ack(n);
    req_valid = '0;
    vectors++;
    if (req_ack !== 4'b0010 || i2c_start !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ack: ack=%b start=%b busy=%b, want 0010/1/1", req_ack, i2c_start, busy);
    end
    vectors++;
    if ({i2c_dev_addr, i2c_reg_addr, i2c_data} !== 24'h3C10A5) begin
      miscompares++;
      $display("FAIL single_payload: got %h%h%h, want 3c10a5", i2c_dev_addr, i2c_reg_addr, i2c_data);
    end
    cyc();
    vectors++;
    if (req_ack !== '0) begin
      miscompares++;
      $display("FAIL single_ack_pulse: ack=%b, want 0000", req_ack);
    end
    seen_low = 1'b0;
    n = 0;
    while (i2c_start === 1'b1 && n < 100) begin
      if (i2c_ready === 1'b0) seen_low = 1'b1;
      cyc();
      n++;
    end
    vectors++;
    if (seen_low !== 1'b1 || n >= 100) begin
      miscompares++;
      $display("FAIL single_start_hold: ready_low_before_drop=%b cycles=%0d, want 1 and <100", seen_low, n);
    end
    wait_done(n);
    vectors++;
    if (req_done !== 4'b0010 || req_err !== 1'b0 || grant_id !== GW'(1) || i2c_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_done: done=%b err=%b id=%0d dat=%h, want 0010/0/1/a5", req_done, req_err, grant_id, i2c_data);
    end
  endtask

  task automatic test_round_robin();
    int n, bl, ex;
    logic [NUM_REQ-1:0] ev;
    do_reset();
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      ex = g % NUM_REQ;
      ev = '0;
      ev[ex] = 1'b1;
      bl = 0;
      n = 0;
      do begin cyc(); n++; if (busy === 1'b0) bl++; end while (req_ack == '0 && n < 100);
      vectors++;
      if (req_ack !== ev || grant_id !== GW'(ex)) begin
        miscompares++;
        $display("FAIL rr_grant%0d: ack=%b id=%0d, want %b/%0d", g, req_ack, grant_id, ev, ex);
      end
      if (g > 0) begin
        vectors++;
        if (bl != 1) begin
          miscompares++;
          $display("FAIL rr_idle_gap%0d: busy low %0d cycles, want 1", g, bl);
        end
      end
      req_valid[ex] = 1'b0;
      cyc();
      req_valid[ex] = 1'b1;
      wait_done(n);
      vectors++;
      if (req_done !== ev || req_err !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_done%0d: done=%b err=%b, want %b/0", g, req_done, req_err, ev);
      end
    end
    req_valid = '0;
    repeat (3) cyc();
  endtask

  task automatic test_launch_timeout();
    int n, hi;
    model_en = 1'b0;
    forced_ready = 1'b1;
    cyc();
    req_valid = 4'b0100;
    wait_ack(n);
    req_valid = '0;
    vectors++;
    if (req_ack !== 4'b0100) begin
      miscompares++;
      $display("FAIL lto_ack: ack=%b, want 0100", req_ack);
    end
    hi = 0;
    while (i2c_start === 1'b1 && hi < 200) begin hi++; cyc(); end
    vectors++;
    if (hi != TIMEOUT_CYCLES) begin
      miscompares++;
      $display("FAIL lto_start_len: start high %0d cycles, want %0d", hi, TIMEOUT_CYCLES);
    end
    vectors++;
    if (req_done !== 4'b0100 || req_err !== 1'b1) begin
      miscompares++;
      $display("FAIL lto_done: done=%b err=%b, want 0100/1", req_done, req_err);
    end
    cyc();
    vectors++;
    if (req_done !== '0 || req_err !== 1'b0) begin
      miscompares++;
      $display("FAIL lto_err_qual: done=%b err=%b, want 0000/0", req_done, req_err);
    end
    model_en = 1'b1;
    req_valid = 4'b1000;
    wait_ack(n);
    req_valid = '0;
    vectors++;
    if (req_ack !== 4'b1000) begin
      miscompares++;
      $display("FAIL lto_next_ack: ack=%b, want 1000", req_ack);
    end
    wait_done(n);
    vectors++;
    if (req_done !== 4'b1000 || req_err !== 1'b0) begin
      miscompares++;
      $display("FAIL lto_next_done: done=%b err=%b, want 1000/0", req_done, req_err);
    end
  endtask

  task automatic test_wait_timeout();
    int n, k;
    model_hang = 1'b1;
    req_valid = 4'b0001;
    wait_ack(n);
    req_valid = '0;
    n = 0;
    while (i2c_start === 1'b1 && n < 100) begin cyc(); n++; end
    k = 0;
    while (req_done === '0 && k < 200) begin cyc(); k++; end
    vectors++;
    if (k != TIMEOUT_CYCLES || req_done !== 4'b0001 || req_err !== 1'b1) begin
      miscompares++;
      $display("FAIL wto: done after %0d cycles done=%b err=%b, want %0d/0001/1", k, req_done, req_err, TIMEOUT_CYCLES);
    end
    model_hang = 1'b0;
    model_en = 1'b0;
    cyc();
    model_en = 1'b1;
  endtask

  task automatic test_payload_stability();
    int n, bad;
    req_dev_addr[7:0] = 8'h50;
    req_reg_addr[7:0] = 8'h01;
    req_data[7:0]     = 8'h11;
    req_valid         = 4'b0001;
    wait_ack(n);
    req_valid = '0;
    vectors++;
    if (req_ack !== 4'b0001 || i2c_data !== 8'h11) begin
      miscompares++;
      $display("FAIL pay_ack: ack=%b dat=%h, want 0001/11", req_ack, i2c_data);
    end
    cyc();
    req_data[7:0] = 8'h22;
    req_dev_addr[7:0] = 8'hFF;
    bad = 0;
    n = 0;
    while (req_done === '0 && n < 300) begin
      cyc();
      n++;
      if (i2c_data !== 8'h11 || i2c_dev_addr !== 8'h50) bad++;
    end
    vectors++;
    if (bad != 0 || req_done !== 4'b0001) begin
      miscompares++;
      $display("FAIL pay_stable: %0d bad cycles done=%b dat=%h, want 0/0001/11", bad, req_done, i2c_data);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n, bad, lo;
    logic [NUM_REQ-1:0] v, ev;
    model_hang = 1'b1;
    req_valid = 4'b0100;
    wait_ack(n);
    req_valid = '0;
    n = 0;
    while (i2c_start === 1'b1 && n < 100) begin cyc(); n++; end
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    vectors++;
    if ({req_ack, req_done, req_err, i2c_start, i2c_dev_addr, i2c_reg_addr, i2c_data, busy, grant_id} !== '0) begin
      miscompares++;
      $display("FAIL rst_wait: ack=%b done=%b start=%b busy=%b id=%0d dat=%h, want 0", req_ack, req_done, i2c_start, busy, grant_id, i2c_data);
    end
    reset = 1'b0;
    model_hang = 1'b0;
    model_en = 1'b0;
    cyc();
    model_en = 1'b1;
    bad = 0;
    repeat (10) begin cyc(); if (req_done !== '0) bad++; end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rst_no_done: %0d done pulses, want 0", bad);
    end
    v = NUM_REQ'($urandom_range(2, 15));
    lo = -1;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (v[i]) lo = i;
    ev = '0;
    ev[lo] = 1'b1;
    req_valid = v;
    wait_ack(n);
    req_valid = v & ~ev;
    vectors++;
    if (req_ack !== ev) begin
      miscompares++;
      $display("FAIL rst_next_grant: valid=%b ack=%b, want %b", v, req_ack, ev);
    end
    req_valid = '0;
    wait_done(n);
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] applied, ev;
    logic [7:0] pd [NUM_REQ];
    logic [7:0] pr [NUM_REQ];
    logic [7:0] pt [NUM_REQ];
    int wc [NUM_REQ];
    int last, owner, grants, guard, ex;
    do_reset();
    last = NUM_REQ - 1;
    owner = -1;
    grants = 0;
    guard = 0;
    for (int i = 0; i < NUM_REQ; i++) wc[i] = 0;
    while (grants < 150 && guard < 20000) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          pd[i] = 8'($urandom);
          pr[i] = 8'($urandom);
          pt[i] = 8'($urandom);
          req_dev_addr[8*i +: 8] = pd[i];
          req_reg_addr[8*i +: 8] = pr[i];
          req_data[8*i +: 8]     = pt[i];
          req_valid[i] = 1'b1;
          wc[i] = 0;
        end
      end
      applied = req_valid;
      cyc();
      guard++;
      if (req_ack !== '0) begin
        ex = rr_pick(applied, last);
        ev = '0;
        if (ex >= 0) ev[ex] = 1'b1;
        vectors++;
        if (ex < 0 || req_ack !== ev || grant_id !== GW'(ex) || busy !== 1'b1 ||
            i2c_dev_addr !== pd[ex] || i2c_reg_addr !== pr[ex] || i2c_data !== pt[ex]) begin
          miscompares++;
          $display("FAIL rand_grant: valid=%b ack=%b id=%0d, want grant %0d", applied, req_ack, grant_id, ex);
        end
        if (ex >= 0) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (i != ex && applied[i]) begin
              wc[i]++;
              vectors++;
              if (wc[i] > NUM_REQ - 1) begin
                miscompares++;
                $display("FAIL rand_fair: req %0d waited %0d grants, want <= %0d", i, wc[i], NUM_REQ - 1);
              end
            end
          end
          last = ex;
          owner = ex;
          req_valid[ex] = 1'b0;
        end
        grants++;
      end
      if (req_done !== '0) begin
        ev = '0;
        if (owner >= 0) ev[owner] = 1'b1;
        vectors++;
        if (owner < 0 || req_done !== ev || req_err !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_done: done=%b err=%b, want owner %0d err 0", req_done, req_err, owner);
        end
        owner = -1;
      end else begin
        vectors++;
        if (req_err !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_err_qual: err=%b without done", req_err);
        end
      end
    end
    vectors++;
    if (grants < 150) begin
      miscompares++;
      $display("FAIL rand_progress: %0d grants in %0d cycles, want 150", grants, guard);
    end
    req_valid = '0;
    repeat (40) cyc();
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = '0;
    req_dev_addr = '0;
    req_reg_addr = '0;
    req_data     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_launch_timeout();
    test_wait_timeout();
    test_payload_stability();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
